// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and constants for the I2C register burst reader
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_EMIT,
    ST_FINISH,
    ST_ABORT
  } state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam int TMO_W = 16;

endpackage

// File: rtl/i2c_handshake.sv
// rtl/i2c_handshake.sv - enable/ready request-wait handshake with per-state timeout counter
module i2c_handshake
  import i2c_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic pending,
  input  logic clear,
  input  logic ready,
  output logic accepted,
  output logic completed,
  output logic timed_out
);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts cycles spent in the current request/wait state; a state change restarts it.
  always_ff @(posedge clk) begin
    if (rst || clear || !(req || pending)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign accepted  = req && !ready;
  assign completed = pending && ready;
  assign timed_out = (req || pending) && (tmo_cnt >= TMO_W'(TIMEOUT - 1'b1));

endmodule

// File: rtl/i2c_reg_burst_reader.sv
// rtl/i2c_reg_burst_reader.sv - reads NUM_REGS consecutive sensor registers through the I2C master
module i2c_reg_burst_reader
  import i2c_pkg::*;
#(
  parameter logic [6:0]       DEV_ADDR  = 7'h68,
  parameter logic [7:0]       START_REG = 8'h3B,
  parameter int               NUM_REGS  = 6,
  parameter logic [TMO_W-1:0] TIMEOUT   = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] byte_data,
  output logic [3:0] byte_idx,
  output logic       byte_valid,
  output logic       ctrl_enable,
  output logic [6:0] ctrl_addr,
  output logic       ctrl_rw,
  output logic [7:0] ctrl_data_in,
  input  logic       ctrl_ready,
  input  logic [7:0] ctrl_data_out
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t     state, state_next;
  logic [7:0] ptr;
  logic [3:0] cnt;
  logic       hs_req, hs_pending, hs_accepted, hs_completed, hs_timed_out;

  assign hs_req     = (state == ST_WR_REQ) || (state == ST_RD_REQ);
  assign hs_pending = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);

  i2c_handshake #(.TIMEOUT(TIMEOUT)) u_handshake (
    .clk       (clk),
    .rst       (rst),
    .req       (hs_req),
    .pending   (hs_pending),
    .clear     (state_next != state),
    .ready     (ctrl_ready),
    .accepted  (hs_accepted),
    .completed (hs_completed),
    .timed_out (hs_timed_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= START_REG;
      cnt       <= '0;
      error     <= 1'b0;
      byte_data <= '0;
      byte_idx  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        ptr   <= START_REG;
        cnt   <= '0;
        error <= 1'b0;
      end
      if (state == ST_RD_WAIT && hs_completed) begin
        byte_data <= ctrl_data_out;
        byte_idx  <= cnt;
      end
      if (state == ST_EMIT && cnt != LAST_IDX) begin
        ptr <= ptr + 8'd1;
        cnt <= cnt + 4'd1;
      end
      if (state_next == ST_ABORT) begin
        error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    byte_valid  = 1'b0;
    ctrl_enable = 1'b0;
    ctrl_rw     = I2C_RW_WRITE;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        busy        = 1'b1;
        ctrl_enable = 1'b1;
        if (hs_accepted)       state_next = ST_WR_WAIT;
        else if (hs_timed_out) state_next = ST_ABORT;
      end
      ST_WR_WAIT: begin
        busy = 1'b1;
        if (hs_completed)      state_next = ST_RD_REQ;
        else if (hs_timed_out) state_next = ST_ABORT;
      end
      ST_RD_REQ: begin
        busy        = 1'b1;
        ctrl_enable = 1'b1;
        ctrl_rw     = I2C_RW_READ;
        if (hs_accepted)       state_next = ST_RD_WAIT;
        else if (hs_timed_out) state_next = ST_ABORT;
      end
      ST_RD_WAIT: begin
        busy    = 1'b1;
        ctrl_rw = I2C_RW_READ;
        if (hs_completed)      state_next = ST_EMIT;
        else if (hs_timed_out) state_next = ST_ABORT;
      end
      ST_EMIT: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        state_next = (cnt == LAST_IDX) ? ST_FINISH : ST_WR_REQ;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ABORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ctrl_addr    = DEV_ADDR;
  assign ctrl_data_in = ptr;

endmodule
